alu_microseq: RTL and testbench
===============================

Name: alu_microseq

Overview:
- Accumulator-based micro-sequencer that drives the 8-bit, 5-bit-opcode ALU through a short stored program.
- Host preloads up to DEPTH instructions, pulses start, and the block executes one ALU op per cycle with acc as operand A and the instruction immediate as operand B.
- Sits between the host control path and the shared ALU. Provides early-halt-on-zero, abort, and a one-cycle completion pulse.

Parameters:
DEPTH, 16, number of program slots
AW, 4, program address width (DEPTH = 2**AW)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
prog_we  in  1  program write strobe, honoured only in IDLE
prog_addr  in  AW  program slot to write
prog_data  in  14  instruction {hz[13], op[12:8], imm[7:0]}
start  in  1  begin execution, honoured only in IDLE
len  in  AW+1  number of instructions to run (0..DEPTH), sampled with start
acc_init  in  8  initial accumulator value, sampled with start
abort  in  1  terminate a run immediately
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on normal completion
acc  out  8  accumulator (registered)
zero  out  1  registered (acc == 0)
step  out  AW  index of the most recently executed instruction

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE, acc=0, zero=1, busy=0, done=0, step=0, pc=0. Program memory is not reset and keeps its contents.
- Opcode semantics (F = alu(A=acc, B=imm, S=op)):
  - 000nn: A<<nn
  - 001nn: A>>nn (logical)
  - 010nn: rotate-left by nn
  - 011nn: rotate-right by nn
  - 1000x: 0x00
  - 1001x: 0xFF
  - 10100: A; 10101: B; 10110: -A; 10111: -B
  - 11000: A+B; 11001: A-B
  - 11010: OR; 11011: AND; 11100: NOR; 11101: NAND
  - 11110: ~A; 11111: ~B
  - All results are 8-bit, mod 256; no carry/overflow output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - prog_we writes mem[prog_addr] at the clock edge.
  - start with abort low: acc<=acc_init, pc<=0. Then len==0 goes to DONE; otherwise goes to RUN.
  - start together with abort: start is ignored.
- RUN (busy=1):
  - Per cycle: acc<=F(mem[pc]) and step<=pc.
  - Run ends with a transition to DONE when pc==len-1, or when hz=1 and F==0 (halt-on-zero).
  - Otherwise pc<=pc+1.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- Latency: start at edge 0 executes instruction k in cycle k+1. For a full run, done is high in cycle len+1.
- abort in RUN:
  - The current instruction is not executed; acc holds its value.
  - Next state is IDLE, no done pulse.
  - abort has priority over end-of-run in the same cycle.
- In RUN or DONE, start and prog_we are ignored.
- prog_we and start in the same IDLE cycle: the write lands first, so the run sees the new data.
- zero is updated on every acc load, including acc_init.
- len > DEPTH is saturated to DEPTH.

Decomposition:
- Package alu_microseq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - opcode localparams (OP_ADD=5'b11000, OP_SUB=5'b11001, OP_PASSB=5'b10101, ...)
  - instruction field offsets
- One sub-module: the existing alu, instantiated with A=acc, B=mem[pc][7:0], S=mem[pc][12:8]. It is purely combinational; the sequencer holds all state.

Test Plan:
1. Normal run: load mem0={0,11000,0x05}, mem1={0,01001,0x00}, mem2={0,11001,0x03}; start with acc_init=0x10, len=3. Required: acc 0x15, then 0x2A, then 0x27; done in cycle 4; busy high cycles 1-3; step=2.
2. Halt-on-zero: mem0={1,11001,0x05}, len=4, acc_init=0x05. Required: acc=0x00, zero=1, done in cycle 2, step=0.
3. Zero-length run: len=0, acc_init=0xAB. Required: done in cycle 1, busy never high, acc=0xAB.
4. Abort: 4-instruction ADD 1 program, acc_init=0, abort asserted in cycle 3. Required: acc=0x02, busy low from cycle 4, no done pulse.
5. Ignored inputs: prog_we and start during RUN. Required: memory unchanged (readback via rerun gives the same acc), run unaffected.
6. Reset mid-run: rst asserted in cycle 2 of a 4-step run. Required: outputs reset immediately without a clock edge (acc=0, zero=1, busy=0); a subsequent start reruns the retained program correctly.

Source files
------------

// File: rtl/alu_microseq_pkg.sv
// alu_microseq_pkg: shared types and constants for the accumulator micro-sequencer.
//   - state_e        : sequencer FSM states
//   - instruction field layout {hz[13], op[12:8], imm[7:0]}
//   - ALU opcode and opcode-group encodings
package alu_microseq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Instruction field layout
    localparam int unsigned InstrW  = 14;
    localparam int unsigned HzBit   = 13;
    localparam int unsigned OpMsb   = 12;
    localparam int unsigned OpLsb   = 8;
    localparam int unsigned ImmMsb  = 7;
    localparam int unsigned ImmLsb  = 0;

    // Opcode groups selected by op[4:2]; op[1:0] is the shift/rotate amount
    localparam logic [2:0] GRP_SHL   = 3'b000;
    localparam logic [2:0] GRP_SHR   = 3'b001;
    localparam logic [2:0] GRP_ROL   = 3'b010;
    localparam logic [2:0] GRP_ROR   = 3'b011;
    localparam logic [2:0] GRP_CONST = 3'b100;

    // Full opcodes
    localparam logic [4:0] OP_ZERO  = 5'b10000;
    localparam logic [4:0] OP_ONES  = 5'b10010;
    localparam logic [4:0] OP_PASSA = 5'b10100;
    localparam logic [4:0] OP_PASSB = 5'b10101;
    localparam logic [4:0] OP_NEGA  = 5'b10110;
    localparam logic [4:0] OP_NEGB  = 5'b10111;
    localparam logic [4:0] OP_ADD   = 5'b11000;
    localparam logic [4:0] OP_SUB   = 5'b11001;
    localparam logic [4:0] OP_OR    = 5'b11010;
    localparam logic [4:0] OP_AND   = 5'b11011;
    localparam logic [4:0] OP_NOR   = 5'b11100;
    localparam logic [4:0] OP_NAND  = 5'b11101;
    localparam logic [4:0] OP_NOTA  = 5'b11110;
    localparam logic [4:0] OP_NOTB  = 5'b11111;

endpackage

// File: rtl/alu_microseq_alu.sv
// alu_microseq_alu: purely combinational 8-bit ALU with a 5-bit opcode.
//   a_i : operand A (accumulator)
//   b_i : operand B (instruction immediate)
//   s_i : opcode
//   f_o : 8-bit result, mod 256, no carry/overflow
module alu_microseq_alu
    import alu_microseq_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [4:0] s_i,
    output logic [7:0] f_o
);

    // Rotates via a doubled operand: the wrapped bits fall out of the other half.
    logic [15:0] dbl_l;
    logic [15:0] dbl_r;

    always_comb begin
        dbl_l = {a_i, a_i} << s_i[1:0];
        dbl_r = {a_i, a_i} >> s_i[1:0];
        f_o   = 8'h00;
        unique case (s_i[4:2])
            GRP_SHL:   f_o = a_i << s_i[1:0];
            GRP_SHR:   f_o = a_i >> s_i[1:0];
            GRP_ROL:   f_o = dbl_l[15:8];
            GRP_ROR:   f_o = dbl_r[7:0];
            GRP_CONST: f_o = s_i[1] ? 8'hFF : 8'h00;
            default: begin
                case (s_i)
                    OP_PASSA: f_o = a_i;
                    OP_PASSB: f_o = b_i;
                    OP_NEGA:  f_o = -a_i;
                    OP_NEGB:  f_o = -b_i;
                    OP_ADD:   f_o = a_i + b_i;
                    OP_SUB:   f_o = a_i - b_i;
                    OP_OR:    f_o = a_i | b_i;
                    OP_AND:   f_o = a_i & b_i;
                    OP_NOR:   f_o = ~(a_i | b_i);
                    OP_NAND:  f_o = ~(a_i & b_i);
                    OP_NOTA:  f_o = ~a_i;
                    OP_NOTB:  f_o = ~b_i;
                    default:  f_o = 8'h00;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_microseq.sv
// alu_microseq: accumulator-based micro-sequencer driving the shared ALU.
// The host loads a program while idle, then pulses start; one instruction runs
// per cycle with acc as operand A and the instruction immediate as operand B.
//   clk, rst          : clock, asynchronous active-high reset
//   prog_we/addr/data : program slot write (idle only)
//   start, len,       : launch a run of len instructions from acc_init (idle only)
//   acc_init
//   abort             : stop a run without executing the current instruction
//   busy, done        : running flag, one-cycle normal-completion pulse
//   acc, zero, step   : accumulator, acc==0 flag, last executed slot
module alu_microseq
    import alu_microseq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [InstrW-1:0] prog_data,
    input  logic              start,
    input  logic [AW:0]       len,
    input  logic [7:0]        acc_init,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [7:0]        acc,
    output logic              zero,
    output logic [AW-1:0]     step
);

    localparam logic [AW:0]   DepthLen = DEPTH[AW:0];
    localparam logic [AW:0]   OneLen   = 1;
    localparam logic [AW-1:0] OnePc    = 1;

    // Program memory is deliberately not reset so it survives rst.
    logic [InstrW-1:0] mem_q [DEPTH];

    state_e        state_q, state_d;
    logic [7:0]    acc_q, acc_d;
    logic          zero_q, zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] step_q, step_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;

    logic [InstrW-1:0] instr;
    logic [7:0]        alu_f;
    logic [AW:0]       len_sat;
    logic              last_instr;
    logic              halt_zero;

    assign instr = mem_q[pc_q];

    alu_microseq_alu u_alu (
        .a_i (acc_q),
        .b_i (instr[ImmMsb:ImmLsb]),
        .s_i (instr[OpMsb:OpLsb]),
        .f_o (alu_f)
    );

    always_ff @(posedge clk) begin
        if (prog_we && (state_q == StIdle)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        step_d  = step_q;
        pc_d    = pc_q;
        len_d   = len_q;

        len_sat    = (len > DepthLen) ? DepthLen : len;
        last_instr = ({1'b0, pc_q} == (len_q - OneLen));
        halt_zero  = instr[HzBit] && (alu_f == 8'h00);

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    acc_d   = acc_init;
                    zero_d  = (acc_init == 8'h00);
                    pc_d    = '0;
                    len_d   = len_sat;
                    state_d = (len_sat == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // abort wins over end-of-run and suppresses the current instruction
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d  = alu_f;
                    zero_d = (alu_f == 8'h00);
                    step_d = pc_q;
                    if (last_instr || halt_zero) begin
                        state_d = StDone;
                    end else begin
                        pc_d = pc_q + OnePc;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= 8'h00;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            pc_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            step_q  <= step_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign acc  = acc_q;
    assign zero = zero_q;
    assign step = step_q;

endmodule

// File: tb/tb_alu_microseq.sv
// tb_alu_microseq: directed self-checking bench for alu_microseq.
// Inputs change and outputs are sampled on the falling edge; "cycle k" is the
// period following rising edge k, where edge 0 samples start.
module tb_alu_microseq;
    import alu_microseq_pkg::*;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [13:0] prog_data;
    logic        start;
    logic [4:0]  len;
    logic [7:0]  acc_init;
    logic        abort;
    logic        busy;
    logic        done;
    logic [7:0]  acc;
    logic        zero;
    logic [3:0]  step;

    int n_checks = 0;
    int n_fail   = 0;

    alu_microseq #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .len       (len),
        .acc_init  (acc_init),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .acc       (acc),
        .zero      (zero),
        .step      (step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] ins(input logic hz, input logic [4:0] op,
                                        input logic [7:0] imm);
        return {hz, op, imm};
    endfunction

    // Stimulus only: one program write, called on a falling edge.
    task automatic prog(input logic [3:0] a, input logic [13:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Stimulus only: pulse start; returns on the falling edge of cycle 1.
    task automatic kick(input logic [4:0] l, input logic [7:0] ai);
        start    = 1'b1;
        len      = l;
        acc_init = ai;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, acc, zero, step} !== {1'b0, 1'b0, 8'h00, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b acc=%h zero=%b step=%h, need 0 0 00 1 0",
                     busy, done, acc, zero, step);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal_run;
        prog(4'd0, ins(1'b0, OP_ADD, 8'h05));
        prog(4'd1, ins(1'b0, 5'b01001, 8'h00));  // rotate left by 1
        prog(4'd2, ins(1'b0, OP_SUB, 8'h03));
        kick(5'd3, 8'h10);
        n_checks++;
        if ({busy, done, acc} !== {1'b1, 1'b0, 8'h10}) begin
            n_fail++;
            $display("FAIL normal_c1: got busy=%b done=%b acc=%h, need 1 0 10", busy, done, acc);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, acc} !== {1'b1, 8'h15}) begin
            n_fail++;
            $display("FAIL normal_c2: got busy=%b acc=%h, need 1 15", busy, acc);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, acc} !== {1'b1, 8'h2A}) begin
            n_fail++;
            $display("FAIL normal_c3: got busy=%b acc=%h, need 1 2a", busy, acc);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, acc, zero, step} !== {1'b0, 1'b1, 8'h27, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL normal_c4: got busy=%b done=%b acc=%h zero=%b step=%h, need 0 1 27 0 2",
                     busy, done, acc, zero, step);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL normal_c5: got busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_halt_zero;
        prog(4'd0, ins(1'b1, OP_SUB, 8'h05));
        kick(5'd4, 8'h05);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_c1: got busy=%b, need 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, acc, zero, step} !== {1'b0, 1'b1, 8'h00, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL halt_c2: got busy=%b done=%b acc=%h zero=%b step=%h, need 0 1 00 1 0",
                     busy, done, acc, zero, step);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_len;
        kick(5'd0, 8'hAB);
        n_checks++;
        if ({busy, done, acc, zero} !== {1'b0, 1'b1, 8'hAB, 1'b0}) begin
            n_fail++;
            $display("FAIL zerolen_c1: got busy=%b done=%b acc=%h zero=%b, need 0 1 ab 0",
                     busy, done, acc, zero);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, acc} !== {1'b0, 1'b0, 8'hAB}) begin
            n_fail++;
            $display("FAIL zerolen_c2: got busy=%b done=%b acc=%h, need 0 0 ab", busy, done, acc);
        end
    endtask

    task automatic test_abort;
        for (int i = 0; i < 4; i++) prog(4'(i), ins(1'b0, OP_ADD, 8'h01));
        // start together with abort in idle is ignored
        abort = 1'b1;
        kick(5'd4, 8'h00);
        abort = 1'b0;
        n_checks++;
        if ({busy, done, acc} !== {1'b0, 1'b0, 8'hAB}) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy=%b done=%b acc=%h, need 0 0 ab",
                     busy, done, acc);
        end
        kick(5'd4, 8'h00);
        @(negedge clk);                        // cycle 2
        @(negedge clk);                        // cycle 3
        n_checks++;
        if ({busy, acc} !== {1'b1, 8'h02}) begin
            n_fail++;
            $display("FAIL abort_c3: got busy=%b acc=%h, need 1 02", busy, acc);
        end
        abort = 1'b1;
        @(negedge clk);                        // cycle 4
        abort = 1'b0;
        n_checks++;
        if ({busy, done, acc, step} !== {1'b0, 1'b0, 8'h02, 4'd1}) begin
            n_fail++;
            $display("FAIL abort_c4: got busy=%b done=%b acc=%h step=%h, need 0 0 02 1",
                     busy, done, acc, step);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, acc} !== {1'b0, 1'b0, 8'h02}) begin
            n_fail++;
            $display("FAIL abort_c5: got busy=%b done=%b acc=%h, need 0 0 02", busy, done, acc);
        end
    endtask

    task automatic test_ignored_inputs;
        kick(5'd4, 8'h20);
        prog_we   = 1'b1;
        prog_addr = 4'd2;
        prog_data = ins(1'b0, OP_PASSB, 8'h00);
        start     = 1'b1;
        len       = 5'd1;
        acc_init  = 8'h00;
        @(negedge clk);                        // cycle 2
        n_checks++;
        if ({busy, acc} !== {1'b1, 8'h21}) begin
            n_fail++;
            $display("FAIL ignored_c2: got busy=%b acc=%h, need 1 21", busy, acc);
        end
        @(negedge clk);                        // cycle 3
        prog_we = 1'b0;
        start   = 1'b0;
        @(negedge clk);                        // cycle 4
        @(negedge clk);                        // cycle 5
        n_checks++;
        if ({busy, done, acc} !== {1'b0, 1'b1, 8'h24}) begin
            n_fail++;
            $display("FAIL ignored_c5: got busy=%b done=%b acc=%h, need 0 1 24", busy, done, acc);
        end
        @(negedge clk);
        kick(5'd4, 8'h20);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({done, acc} !== {1'b1, 8'h24}) begin
            n_fail++;
            $display("FAIL ignored_rerun: got done=%b acc=%h, need 1 24", done, acc);
        end
        @(negedge clk);
    endtask

    task automatic test_len_saturation;
        for (int i = 0; i < 16; i++) prog(4'(i), ins(1'b0, OP_ADD, 8'h01));
        kick(5'd20, 8'h00);
        repeat (15) @(negedge clk);            // cycle 16
        n_checks++;
        if ({busy, done, acc} !== {1'b1, 1'b0, 8'h0F}) begin
            n_fail++;
            $display("FAIL sat_c16: got busy=%b done=%b acc=%h, need 1 0 0f", busy, done, acc);
        end
        @(negedge clk);                        // cycle 17
        n_checks++;
        if ({busy, done, acc, step} !== {1'b0, 1'b1, 8'h10, 4'd15}) begin
            n_fail++;
            $display("FAIL sat_c17: got busy=%b done=%b acc=%h step=%h, need 0 1 10 f",
                     busy, done, acc, step);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        kick(5'd4, 8'h50);
        @(negedge clk);                        // cycle 2
        n_checks++;
        if ({busy, acc} !== {1'b1, 8'h51}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy=%b acc=%h, need 1 51", busy, acc);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, acc, zero, step} !== {1'b0, 1'b0, 8'h00, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%b done=%b acc=%h zero=%b step=%h, need 0 0 00 1 0",
                     busy, done, acc, zero, step);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        kick(5'd4, 8'h50);
        repeat (4) @(negedge clk);             // cycle 5
        n_checks++;
        if ({busy, done, acc, step} !== {1'b0, 1'b1, 8'h54, 4'd3}) begin
            n_fail++;
            $display("FAIL rstmid_rerun: got busy=%b done=%b acc=%h step=%h, need 0 1 54 3",
                     busy, done, acc, step);
        end
        @(negedge clk);
    endtask

    task automatic test_write_with_start;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = ins(1'b0, OP_PASSB, 8'h77);
        kick(5'd1, 8'h01);
        prog_we = 1'b0;
        n_checks++;
        if ({busy, acc} !== {1'b1, 8'h01}) begin
            n_fail++;
            $display("FAIL wrstart_c1: got busy=%b acc=%h, need 1 01", busy, acc);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, acc, step} !== {1'b0, 1'b1, 8'h77, 4'd0}) begin
            n_fail++;
            $display("FAIL wrstart_c2: got busy=%b done=%b acc=%h step=%h, need 0 1 77 0",
                     busy, done, acc, step);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        len       = '0;
        acc_init  = '0;
        abort     = 1'b0;
        test_reset();
        test_normal_run();
        test_halt_zero();
        test_zero_len();
        test_abort();
        test_ignored_inputs();
        test_len_saturation();
        test_reset_mid_run();
        test_write_with_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
